ram_responder: RTL and testbench

- Memory-side endpoint of the cpu_ram interface: the RAM model/controller that answers memaddr/memstore/memREN/memWEN with ramload/ramstate.
- Sits below the memory controller in the simulation top and the synthesis wrapper.
- Contains a word-addressed storage array, a programmable access latency, and request-change/abort detection.
- Lets the cache/coherence stack be exercised against realistic multi-cycle RAM timing.

---
 rtl/ram_responder.sv | 126 ++++++++++++
 tb/tb_ram_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// ram_responder: memory-side endpoint of the cpu_ram interface.
// Word-addressed storage array answering memaddr/memstore/memREN/memWEN
// with ramload/ramstate after a programmable number of BUSY cycles.
// Request changes in BUSY restart the wait, withdrawn requests abort with
// no array side effect, and illegal requests report ERROR.
//
// Ports:
//   CLK       in   1  clock, rising edge
//   RST       in   1  synchronous active-high reset
//   memaddr   in  32  byte address of the request
//   memstore  in  32  write data
//   memREN    in   1  read request
//   memWEN    in   1  write request
//   ramload   out 32  read data, nonzero only while ramstate = ACCESS
//   ramstate  out  2  FREE=00, BUSY=01, ACCESS=10, ERROR=11
module ram_responder #(
    parameter int unsigned ADDR_BITS = 14,
    parameter int unsigned LAT       = 2,
    parameter logic [31:0] BASE      = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] memaddr,
    input  logic [31:0] memstore,
    input  logic        memREN,
    input  logic        memWEN,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    // State encoding doubles as the ramstate code, so the output is the
    // state register itself.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        DONE  = 2'b10,
        FAULT = 2'b11
    } state_t;

    localparam logic [3:0] RELOAD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    state_t      state;
    logic [3:0]  cnt;
    logic [65:0] latched;
    logic [31:0] mem [0:(1 << ADDR_BITS) - 1];

    logic [31:0]          off;
    logic [ADDR_BITS-1:0] index;
    logic                 in_range;
    logic                 req;
    logic                 illegal;
    logic [65:0]          tuple;
    logic                 changed;
    logic                 go_access;

    always_comb begin
        off      = memaddr - BASE;
        index    = off[ADDR_BITS+1:2];
        in_range = (memaddr >= BASE) && ((off >> (ADDR_BITS + 2)) == '0);
        req      = memREN | memWEN;
        illegal  = req && ((memREN && memWEN) || (memaddr[1:0] != 2'b00) || !in_range);
        tuple    = {memaddr, memstore, memREN, memWEN};
        changed  = (tuple != latched);
        // The array is touched exactly on the edge that enters DONE.
        go_access = req && !illegal &&
                    ((((state == IDLE) || (state == DONE)) && (LAT == 0)) ||
                     ((state == WAIT) && !changed && (cnt == '0)));
    end

    always_ff @(posedge CLK) begin
        if (!RST && go_access && memWEN) begin
            mem[index] <= memstore;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            latched <= '0;
            ramload <= '0;
        end else begin
            ramload <= (go_access && memREN) ? mem[index] : '0;
            if (illegal) begin
                state <= FAULT;
            end else begin
                case (state)
                    // DONE behaves like IDLE: a request still present is a
                    // fresh request, so back-to-back accesses get no FREE gap.
                    IDLE, DONE: begin
                        if (req) begin
                            latched <= tuple;
                            if (LAT == 0) begin
                                state <= DONE;
                            end else begin
                                state <= WAIT;
                                cnt   <= RELOAD;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                    WAIT: begin
                        if (!req) begin
                            state <= IDLE;
                        end else if (changed) begin
                            latched <= tuple;
                            cnt     <= RELOAD;
                        end else if (cnt == '0) begin
                            state <= DONE;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    // Leaving FAULT always passes through IDLE, even when a
                    // legal request is already waiting.
                    FAULT: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign ramstate = state;

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;

    localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACC = 2'b10, ERR = 2'b11;
    localparam longint unsigned WORDS = 16384;
    localparam longint unsigned TOP   = 4 * WORDS;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] memaddr = '0;
    logic [31:0] memstore = '0;
    logic        memREN = 1'b0;
    logic        memWEN = 1'b0;
    logic [31:0] ramload2, ramload0;
    logic [1:0]  ramstate2, ramstate0;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 CLK = ~CLK;

    ram_responder #(.ADDR_BITS(14), .LAT(2), .BASE(32'h0)) u2 (
        .CLK(CLK), .RST(RST), .memaddr(memaddr), .memstore(memstore),
        .memREN(memREN), .memWEN(memWEN), .ramload(ramload2), .ramstate(ramstate2)
    );

    ram_responder #(.ADDR_BITS(14), .LAT(0), .BASE(32'h0)) u0 (
        .CLK(CLK), .RST(RST), .memaddr(memaddr), .memstore(memstore),
        .memREN(memREN), .memWEN(memWEN), .ramload(ramload0), .ramstate(ramstate0)
    );

    // Reference model, one slot per DUT (0: LAT=2, 1: LAT=0).
    // p = position within the current request's run of edges: 1..lat are
    // BUSY, lat+1 is ACCESS; 0 means no run in progress.
    int          p      [2];
    bit          err    [2];
    logic [65:0] last   [2];
    bit [31:0]   mm     [2][16384];
    bit          mv     [2][16384];
    logic [1:0]  est    [2];
    logic [31:0] eld    [2];
    bit          eld_ok [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input int lat);
        bit          req, bad;
        longint      a;
        int          idx;
        logic [65:0] tup;
        req = memREN || memWEN;
        a   = longint'(memaddr);
        bad = req && ((memREN && memWEN) || (a % 4 != 0) || (a >= longint'(TOP)));
        tup = {memaddr, memstore, memREN, memWEN};
        eld[i] = '0;
        eld_ok[i] = 1'b1;
        if (RST) begin
            p[i] = 0; err[i] = 0; est[i] = FREE;
        end else if (bad) begin
            p[i] = 0; err[i] = 1; est[i] = ERR;
        end else if (err[i]) begin
            p[i] = 0; err[i] = 0; est[i] = FREE;
        end else if (!req) begin
            p[i] = 0; est[i] = FREE;
        end else begin
            if (p[i] == 0 || p[i] == lat + 1 || tup != last[i]) p[i] = 1;
            else p[i] = p[i] + 1;
            last[i] = tup;
            if (p[i] <= lat) begin
                est[i] = BUSY;
            end else begin
                est[i] = ACC;
                idx = int'(a / 4);
                if (memWEN) begin
                    mm[i][idx] = memstore;
                    mv[i][idx] = 1'b1;
                end else begin
                    eld[i] = mm[i][idx];
                    eld_ok[i] = mv[i][idx];
                end
            end
        end
    endtask

    // Drive one cycle, advance both models, and compare both DUTs after the edge.
    task automatic apply(input bit rst, input bit ren, input bit wen,
                         input logic [31:0] addr, input logic [31:0] data);
        RST = rst; memREN = ren; memWEN = wen; memaddr = addr; memstore = data;
        model_step(0, 2);
        model_step(1, 0);
        @(posedge CLK);
        #1;
        check("lat2_state", {30'd0, ramstate2}, {30'd0, est[0]});
        check("lat0_state", {30'd0, ramstate0}, {30'd0, est[1]});
        if (eld_ok[0]) check("lat2_load", ramload2, eld[0]);
        if (eld_ok[1]) check("lat0_load", ramload0, eld[1]);
    endtask

    typedef struct {
        bit          rst;
        bit          ren;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  st;
        logic [31:0] load;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input bit ren, input bit wen, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] st, input logic [31:0] load);
        vec_t v;
        v.rst = rst; v.ren = ren; v.wen = wen; v.addr = addr; v.data = data;
        v.st = st; v.load = load;
        tbl.push_back(v);
    endtask

    logic [31:0] pool [8];

    initial begin
        for (int i = 0; i < 2; i++) begin
            p[i] = 0; err[i] = 0; last[i] = '0;
        end

        // Expected values are for the LAT=2 instance.
        // reset / idle
        add(1, 0, 0, 32'h0,     32'h0,        FREE, 32'h0);
        add(1, 0, 0, 32'h0,     32'h0,        FREE, 32'h0);
        add(0, 0, 0, 32'h0,     32'h0,        FREE, 32'h0);
        add(0, 0, 0, 32'h0,     32'h0,        FREE, 32'h0);
        // write 0x10 then read it back, no gap
        add(0, 0, 1, 32'h10,    32'hDEADBEEF, BUSY, 32'h0);
        add(0, 0, 1, 32'h10,    32'hDEADBEEF, BUSY, 32'h0);
        add(0, 0, 1, 32'h10,    32'hDEADBEEF, ACC,  32'h0);
        add(0, 1, 0, 32'h10,    32'h0,        BUSY, 32'h0);
        add(0, 1, 0, 32'h10,    32'h0,        BUSY, 32'h0);
        add(0, 1, 0, 32'h10,    32'h0,        ACC,  32'hDEADBEEF);
        add(0, 0, 0, 32'h0,     32'h0,        FREE, 32'h0);
        // preload 0x24, 0x20, 0x30
        for (int k = 0; k < 3; k++) add(0, 0, 1, 32'h24, 32'h1234, (k == 2) ? ACC : BUSY, 32'h0);
        for (int k = 0; k < 3; k++) add(0, 0, 1, 32'h20, 32'hAAAA5555, (k == 2) ? ACC : BUSY, 32'h0);
        for (int k = 0; k < 3; k++) add(0, 0, 1, 32'h30, 32'h0, (k == 2) ? ACC : BUSY, 32'h0);
        add(0, 0, 0, 32'h0,     32'h0,        FREE, 32'h0);
        // restart: 0x20 for one BUSY cycle, then switch to 0x24
        add(0, 1, 0, 32'h20,    32'h0,        BUSY, 32'h0);
        add(0, 1, 0, 32'h24,    32'h0,        BUSY, 32'h0);
        add(0, 1, 0, 32'h24,    32'h0,        BUSY, 32'h0);
        add(0, 1, 0, 32'h24,    32'h0,        ACC,  32'h1234);
        add(0, 0, 0, 32'h0,     32'h0,        FREE, 32'h0);
        // abort: write 0x30=0x55 withdrawn after one BUSY cycle
        add(0, 0, 1, 32'h30,    32'h55,       BUSY, 32'h0);
        add(0, 0, 0, 32'h0,     32'h0,        FREE, 32'h0);
        add(0, 1, 0, 32'h30,    32'h0,        BUSY, 32'h0);
        add(0, 1, 0, 32'h30,    32'h0,        BUSY, 32'h0);
        add(0, 1, 0, 32'h30,    32'h0,        ACC,  32'h0);
        add(0, 0, 0, 32'h0,     32'h0,        FREE, 32'h0);
        // errors
        add(0, 1, 1, 32'h10,    32'h0,        ERR,  32'h0);
        add(0, 1, 1, 32'h10,    32'h0,        ERR,  32'h0);
        add(0, 0, 0, 32'h0,     32'h0,        FREE, 32'h0);
        add(0, 1, 0, 32'h13,    32'h0,        ERR,  32'h0);
        add(0, 0, 0, 32'h0,     32'h0,        FREE, 32'h0);
        add(0, 1, 0, 32'h10000, 32'h0,        ERR,  32'h0);
        add(0, 0, 0, 32'h0,     32'h0,        FREE, 32'h0);
        // reset during a write's BUSY: word 0x10 must keep DEADBEEF
        add(0, 0, 1, 32'h10,    32'h0BADF00D, BUSY, 32'h0);
        add(1, 0, 1, 32'h10,    32'h0BADF00D, FREE, 32'h0);
        add(0, 0, 0, 32'h0,     32'h0,        FREE, 32'h0);
        add(0, 1, 0, 32'h10,    32'h0,        BUSY, 32'h0);
        add(0, 1, 0, 32'h10,    32'h0,        BUSY, 32'h0);
        add(0, 1, 0, 32'h10,    32'h0,        ACC,  32'hDEADBEEF);
        add(0, 0, 0, 32'h0,     32'h0,        FREE, 32'h0);
        // last legal word
        for (int k = 0; k < 3; k++) add(0, 0, 1, 32'hFFFC, 32'h77, (k == 2) ? ACC : BUSY, 32'h0);
        add(0, 1, 0, 32'hFFFC,  32'h0,        BUSY, 32'h0);
        add(0, 1, 0, 32'hFFFC,  32'h0,        BUSY, 32'h0);
        add(0, 1, 0, 32'hFFFC,  32'h0,        ACC,  32'h77);
        add(0, 0, 0, 32'h0,     32'h0,        FREE, 32'h0);

        foreach (tbl[n]) begin
            apply(tbl[n].rst, tbl[n].ren, tbl[n].wen, tbl[n].addr, tbl[n].data);
            check($sformatf("tbl%0d_state", n), {30'd0, ramstate2}, {30'd0, tbl[n].st});
            check($sformatf("tbl%0d_load", n), ramload2, tbl[n].load);
        end

        // LAT=0 instance answers a read on the first cycle after sampling,
        // and back-to-back requests give ACCESS every cycle.
        apply(0, 1, 0, 32'h24, 32'h0);
        check("lat0_first_state", {30'd0, ramstate0}, {30'd0, ACC});
        check("lat0_first_load", ramload0, 32'h1234);
        check("lat2_first_state", {30'd0, ramstate2}, {30'd0, BUSY});
        apply(0, 1, 0, 32'h20, 32'h0);
        check("lat0_b2b_state", {30'd0, ramstate0}, {30'd0, ACC});
        check("lat0_b2b_load", ramload0, 32'hAAAA5555);
        apply(0, 0, 0, 32'h0, 32'h0);
        check("lat0_idle_state", {30'd0, ramstate0}, {30'd0, FREE});

        // Randomized traffic against the model.
        pool[0] = 32'h0;    pool[1] = 32'h10;   pool[2] = 32'h14;   pool[3] = 32'h20;
        pool[4] = 32'h24;   pool[5] = 32'h30;   pool[6] = 32'hFFF8; pool[7] = 32'hFFFC;
        for (int c = 0; c < 3000; c++) begin
            bit          rst, ren, wen;
            logic [31:0] addr, data;
            int unsigned op;
            rst = ($urandom_range(0, 99) == 0);
            ren = memREN; wen = memWEN; addr = memaddr; data = memstore;
            if ($urandom_range(0, 99) >= 70) begin
                op = $urandom_range(0, 99);
                addr = pool[$urandom_range(0, 7)];
                data = $urandom;
                if (op < 25) begin
                    ren = 0; wen = 0;
                end else if (op < 60) begin
                    ren = 1; wen = 0;
                end else if (op < 90) begin
                    ren = 0; wen = 1;
                end else if (op < 94) begin
                    ren = 1; wen = 1;
                end else if (op < 97) begin
                    ren = 1; wen = 0; addr = addr | 32'($urandom_range(1, 3));
                end else begin
                    ren = 0; wen = 1; addr = 32'h10000 + 32'($urandom_range(0, 3) * 4);
                end
            end
            apply(rst, ren, wen, addr, data);
        end

        apply(0, 0, 0, 32'h0, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
